fetch_target_queue: RTL and testbench
=====================================

FETCH_TARGET_QUEUE -- requirements
Module: fetch_target_queue

Interface
REQ-001 SHALL have parameter DEPTH, default `FTQ_SIZE (16), entry count; power of two, >=4.
REQ-002 SHALL have parameter RDPORT, default `BRU_NUM (2), number of backend read ports.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports i_pred_vld in 1, o_pred_rdy out 1, i_pred_startAddr in `XDEF, i_pred_nextAddr in `XDEF, i_pred_taken in 1: predictor enqueue handshake.
REQ-006 SHALL have ports o_fetch_vld out 1, i_fetch_rdy in 1, o_fetch_ftqIdx out ftqIdx_t, o_fetch_startAddr out `XDEF, o_fetch_nextAddr out `XDEF: fetch-side issue handshake.
REQ-007 SHALL have ports i_read_ftqIdx[RDPORT] in ftqIdx_t, o_read_ftqStartAddr[RDPORT] out `XDEF, o_read_ftqNextAddr[RDPORT] out `XDEF: backend read ports.
REQ-008 SHALL have ports i_branchwb_vld in `WDEF(`BRU_NUM), i_branchwbInfo[`BRU_NUM] in branchwbInfo_t: branch resolution writeback.
REQ-009 SHALL have ports i_commit_vld in 1, i_commit_ftqIdx in ftqIdx_t: retire up to and including that entry.
REQ-010 SHALL have ports i_squash_vld in 1, i_squash_ftqIdx in ftqIdx_t: last surviving entry on squash.
REQ-011 SHALL have port o_count out $clog2(DEPTH)+1: occupied entries.

Function
REQ-012 SHALL keep head (commit), fetch (issue) and tail (enqueue) pointers, each $clog2(DEPTH)+1 bits with MSB wrap bit; ftqIdx_t is the low bits.
REQ-013 SHALL compute full as tail==head with wrap bits differing, empty as exact equality; o_count = tail-head modulo 2^(w).
REQ-014 SHALL drive o_pred_rdy = !full from registered state only (no same-cycle commit credit).
REQ-015 SHALL write entry[tail] and advance tail by 1 on i_pred_vld && o_pred_rdy.
REQ-016 SHALL drive o_fetch_vld = (fetch != tail); advance fetch on o_fetch_vld && i_fetch_rdy; fetch outputs show entry[fetch].
REQ-017 SHALL return read data combinationally, same cycle, from entry[i_read_ftqIdx]; ports independent; reads see pre-edge contents.
REQ-018 SHALL, on branchwb with mispred set, write info.npc into entry[info.ftq_idx].nextAddr next edge; on same-entry conflict lowest port wins.
REQ-019 SHALL, on commit, set head := commit_ftqIdx+1 with wrap bit recomputed relative to head; commit outside [head,tail) is an assertion failure.
REQ-020 SHALL, on squash, set tail and fetch := squash_ftqIdx+1 (wrap relative to head); same-cycle enqueue and fetch advance are dropped.
REQ-021 SHALL apply commit in the same cycle as squash; squash takes priority only over enqueue/fetch.
REQ-022 SHALL permit simultaneous enqueue, fetch, commit and branchwb in one cycle with no stall.

Reset
REQ-023 SHALL, while rst==0 at an edge, clear head/fetch/tail and all entry storage to 0; all inputs ignored.
REQ-024 SHALL hold o_pred_rdy=0, o_fetch_vld=0, o_count=0, all data outputs 0 during reset; o_pred_rdy=1 first cycle after.
REQ-025 SHALL abandon any in-flight handshake on reset mid-operation; no entry survives.

Configuration
REQ-026 SHALL, with FTQ_FETCH_BYPASS_EN defined, when fetch==tail and i_pred_vld&&o_pred_rdy, assert o_fetch_vld same cycle with pred data and ftqIdx=tail; on i_fetch_rdy advance both pointers.
REQ-027 SHALL, without FTQ_FETCH_BYPASS_EN, give minimum enqueue-to-fetch latency of 1 cycle.

Structure
REQ-028 SHALL take ftqIdx_t, branchwbInfo_t (ftq_idx, mispred, npc), `FTQ_SIZE, `BRU_NUM, `XDEF from the shared backend define package; ftqEntry_t (startAddr, nextAddr, taken) added there.
REQ-029 SHALL place pointer arithmetic (increment, wrap-relative set, full/empty) in sub-module ftq_ptr_ctrl.

Verification
REQ-030 Reset then 16 enqueues, no fetch -> o_pred_rdy=0 after 16th, o_count=16, 17th held.
REQ-031 Enqueue start 0x8000 at empty, i_fetch_rdy=1 -> fetch vld cycle 1 (cycle 0 with bypass), ftqIdx=0, startAddr 0x8000.
REQ-032 Fill 5, fetch 5, squash idx 2 with enqueue -> tail=fetch=3, o_count=3, enqueue dropped.
REQ-033 Branchwb ports 0,1 both idx 4 mispred, npc 0x100/0x200 -> read idx 4 next cycle nextAddr=0x100.
REQ-034 Wrap: 40 enqueue/fetch/commit cycles with commit idx 15 -> head wraps to 0, flip wrap bit, o_count correct throughout.

Source files
------------

// File: rtl/fetch_target_queue_pkg.sv
// Shared backend definitions for the fetch target queue: sizing, address
// type, branch writeback record and queue entry layout.
// Optional feature macro used by the top: FTQ_FETCH_BYPASS_EN.
`ifndef FTQ_SIZE
`define FTQ_SIZE 16
`endif
`ifndef BRU_NUM
`define BRU_NUM 2
`endif
`ifndef XDEF
`define XDEF [63:0]
`endif
`ifndef WDEF
`define WDEF(n) [(n)-1:0]
`endif

package fetch_target_queue_pkg;

  localparam int FTQ_SIZE  = `FTQ_SIZE;
  localparam int BRU_NUM   = `BRU_NUM;
  localparam int FTQ_IDX_W = $clog2(FTQ_SIZE);

  typedef logic `XDEF xaddr_t;
  typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;

  typedef struct packed {
    ftqIdx_t ftq_idx;
    logic    mispred;
    xaddr_t  npc;
  } branchwbInfo_t;

  typedef struct packed {
    xaddr_t startAddr;
    xaddr_t nextAddr;
    logic   taken;
  } ftqEntry_t;

endpackage

// File: rtl/ftq_ptr_ctrl.sv
// Head (commit), fetch (issue) and tail (enqueue) pointers of the fetch
// target queue. Pointers carry one extra wrap bit so full and empty are
// distinguishable; commit/squash indices are re-anchored relative to head.
module ftq_ptr_ctrl #(
  parameter int  DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enq,
  input  logic             i_deq,
  input  logic             i_commit_vld,
  input  logic [IDX_W-1:0] i_commit_idx,
  input  logic             i_squash_vld,
  input  logic [IDX_W-1:0] i_squash_idx,
  output logic [IDX_W-1:0] o_tail_idx,
  output logic [IDX_W-1:0] o_fetch_idx,
  output logic             o_full,
  output logic             o_fetch_empty,
  output logic [PTR_W-1:0] o_count
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_fetch;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] w_commit_ptr;
  logic [PTR_W-1:0] w_squash_ptr;
  logic [IDX_W-1:0] w_commit_off;

  // An index at or above head's slot is on head's lap, below it is one lap
  // ahead; the result points one past that entry.
  function automatic logic [PTR_W-1:0] next_rel_head(input logic [PTR_W-1:0] head,
                                                     input logic [IDX_W-1:0] idx);
    logic wrap;
    wrap = (idx >= head[IDX_W-1:0]) ? head[IDX_W] : ~head[IDX_W];
    return {wrap, idx} + PTR_W'(1);
  endfunction

  assign w_commit_ptr  = next_rel_head(r_head, i_commit_idx);
  assign w_squash_ptr  = next_rel_head(r_head, i_squash_idx);
  assign w_commit_off  = i_commit_idx - r_head[IDX_W-1:0];

  assign o_tail_idx    = r_tail[IDX_W-1:0];
  assign o_fetch_idx   = r_fetch[IDX_W-1:0];
  assign o_count       = r_tail - r_head;
  assign o_full        = (r_tail[IDX_W-1:0] == r_head[IDX_W-1:0]) &&
                         (r_tail[IDX_W] != r_head[IDX_W]);
  assign o_fetch_empty = (r_fetch == r_tail);

  // Pointer update: commit always applies; squash overrides enqueue/issue.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_fetch <= '0;
      r_tail  <= '0;
    end else begin
      if (i_commit_vld) begin
        assert ({1'b0, w_commit_off} < o_count);
        r_head <= w_commit_ptr;
      end
      if (i_squash_vld) begin
        r_tail  <= w_squash_ptr;
        r_fetch <= w_squash_ptr;
      end else begin
        if (i_enq) r_tail  <= r_tail + PTR_W'(1);
        if (i_deq) r_fetch <= r_fetch + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: buffers predicted fetch blocks between the branch
// predictor and the fetch unit, serves backend PC lookups, and absorbs
// branch-resolution redirects. Macro FTQ_FETCH_BYPASS_EN lets a freshly
// enqueued block issue to fetch in the same cycle when the queue is drained.
module fetch_target_queue
  import fetch_target_queue_pkg::*;
#(
  parameter int  DEPTH  = FTQ_SIZE,
  parameter int  RDPORT = BRU_NUM,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int PTR_W  = IDX_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_pred_vld,
  output logic                   o_pred_rdy,
  input  xaddr_t                 i_pred_startAddr,
  input  xaddr_t                 i_pred_nextAddr,
  input  logic                   i_pred_taken,
  output logic                   o_fetch_vld,
  input  logic                   i_fetch_rdy,
  output ftqIdx_t                o_fetch_ftqIdx,
  output xaddr_t                 o_fetch_startAddr,
  output xaddr_t                 o_fetch_nextAddr,
  input  ftqIdx_t                i_read_ftqIdx       [RDPORT],
  output xaddr_t                 o_read_ftqStartAddr [RDPORT],
  output xaddr_t                 o_read_ftqNextAddr  [RDPORT],
  input  logic [BRU_NUM-1:0]     i_branchwb_vld,
  input  branchwbInfo_t          i_branchwbInfo      [BRU_NUM],
  input  logic                   i_commit_vld,
  input  ftqIdx_t                i_commit_ftqIdx,
  input  logic                   i_squash_vld,
  input  ftqIdx_t                i_squash_ftqIdx,
  output logic [PTR_W-1:0]       o_count
);

  ftqEntry_t        r_entry [DEPTH];
  logic [IDX_W-1:0] w_tail_idx;
  logic [IDX_W-1:0] w_fetch_idx;
  logic             w_full;
  logic             w_fetch_empty;
  logic [PTR_W-1:0] w_count;
  logic             w_enq_fire;
  logic             w_fetch_fire;

  assign o_pred_rdy   = rst && !w_full;
  assign w_enq_fire   = i_pred_vld && o_pred_rdy;
  assign w_fetch_fire = o_fetch_vld && i_fetch_rdy;
  assign o_count      = rst ? w_count : '0;

  ftq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk           (clk),
    .rst           (rst),
    .i_enq         (w_enq_fire),
    .i_deq         (w_fetch_fire),
    .i_commit_vld  (i_commit_vld),
    .i_commit_idx  (IDX_W'(i_commit_ftqIdx)),
    .i_squash_vld  (i_squash_vld),
    .i_squash_idx  (IDX_W'(i_squash_ftqIdx)),
    .o_tail_idx    (w_tail_idx),
    .o_fetch_idx   (w_fetch_idx),
    .o_full        (w_full),
    .o_fetch_empty (w_fetch_empty),
    .o_count       (w_count)
  );

  // Entry storage: enqueue writes the tail slot, mispredicted branches patch
  // nextAddr; ports are walked high to low so port 0 wins a shared entry.
  // NOTE: the storage is cleared on reset because reset must leave no entry
  // contents behind; this rules out a plain RAM macro for this array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else begin
      if (w_enq_fire && !i_squash_vld) begin
        r_entry[w_tail_idx] <= '{startAddr: i_pred_startAddr,
                                 nextAddr:  i_pred_nextAddr,
                                 taken:     i_pred_taken};
      end
      for (int p = BRU_NUM - 1; p >= 0; p--) begin
        if (i_branchwb_vld[p] && i_branchwbInfo[p].mispred) begin
          r_entry[IDX_W'(i_branchwbInfo[p].ftq_idx)].nextAddr <= i_branchwbInfo[p].npc;
        end
      end
    end
  end

  // Fetch-side view of the oldest un-issued entry, forced to zero in reset.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    o_fetch_vld       = 1'b0;
    o_fetch_ftqIdx    = '0;
    o_fetch_startAddr = '0;
    o_fetch_nextAddr  = '0;
    if (rst) begin
      o_fetch_vld       = !w_fetch_empty;
      o_fetch_ftqIdx    = ftqIdx_t'(w_fetch_idx);
      o_fetch_startAddr = r_entry[w_fetch_idx].startAddr;
      o_fetch_nextAddr  = r_entry[w_fetch_idx].nextAddr;
`ifdef FTQ_FETCH_BYPASS_EN
      if (w_fetch_empty && w_enq_fire) begin
        o_fetch_vld       = 1'b1;
        o_fetch_ftqIdx    = ftqIdx_t'(w_tail_idx);
        o_fetch_startAddr = i_pred_startAddr;
        o_fetch_nextAddr  = i_pred_nextAddr;
      end
`endif
    end
  end

  // Backend lookups read pre-edge storage combinationally, one per port.
  for (genvar g = 0; g < RDPORT; g++) begin : g_read
    assign o_read_ftqStartAddr[g] = rst ? r_entry[IDX_W'(i_read_ftqIdx[g])].startAddr : '0;
    assign o_read_ftqNextAddr[g]  = rst ? r_entry[IDX_W'(i_read_ftqIdx[g])].nextAddr  : '0;
  end

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed bench for fetch_target_queue: reset behaviour, fill to full,
// enqueue-to-fetch latency, squash, branch writeback priority and pointer wrap.
module tb_fetch_target_queue;
  import fetch_target_queue_pkg::*;

  localparam int RD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_pred_vld;
  logic          o_pred_rdy;
  xaddr_t        i_pred_startAddr;
  xaddr_t        i_pred_nextAddr;
  logic          i_pred_taken;
  logic          o_fetch_vld;
  logic          i_fetch_rdy;
  ftqIdx_t       o_fetch_ftqIdx;
  xaddr_t        o_fetch_startAddr;
  xaddr_t        o_fetch_nextAddr;
  ftqIdx_t       i_read_ftqIdx       [RD];
  xaddr_t        o_read_ftqStartAddr [RD];
  xaddr_t        o_read_ftqNextAddr  [RD];
  logic [BRU_NUM-1:0] i_branchwb_vld;
  branchwbInfo_t i_branchwbInfo      [BRU_NUM];
  logic          i_commit_vld;
  ftqIdx_t       i_commit_ftqIdx;
  logic          i_squash_vld;
  ftqIdx_t       i_squash_ftqIdx;
  logic [4:0]    o_count;

  int n_vec = 0;
  int n_err = 0;

  fetch_target_queue #(.DEPTH(16), .RDPORT(RD)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_pred_vld          (i_pred_vld),
    .o_pred_rdy          (o_pred_rdy),
    .i_pred_startAddr    (i_pred_startAddr),
    .i_pred_nextAddr     (i_pred_nextAddr),
    .i_pred_taken        (i_pred_taken),
    .o_fetch_vld         (o_fetch_vld),
    .i_fetch_rdy         (i_fetch_rdy),
    .o_fetch_ftqIdx      (o_fetch_ftqIdx),
    .o_fetch_startAddr   (o_fetch_startAddr),
    .o_fetch_nextAddr    (o_fetch_nextAddr),
    .i_read_ftqIdx       (i_read_ftqIdx),
    .o_read_ftqStartAddr (o_read_ftqStartAddr),
    .o_read_ftqNextAddr  (o_read_ftqNextAddr),
    .i_branchwb_vld      (i_branchwb_vld),
    .i_branchwbInfo      (i_branchwbInfo),
    .i_commit_vld        (i_commit_vld),
    .i_commit_ftqIdx     (i_commit_ftqIdx),
    .i_squash_vld        (i_squash_vld),
    .i_squash_ftqIdx     (i_squash_ftqIdx),
    .o_count             (o_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_pred_vld       = 1'b0;
    i_pred_startAddr = '0;
    i_pred_nextAddr  = '0;
    i_pred_taken     = 1'b0;
    i_fetch_rdy      = 1'b0;
    i_read_ftqIdx[0] = '0;
    i_read_ftqIdx[1] = '0;
    i_branchwb_vld   = '0;
    i_branchwbInfo[0] = '0;
    i_branchwbInfo[1] = '0;
    i_commit_vld     = 1'b0;
    i_commit_ftqIdx  = '0;
    i_squash_vld     = 1'b0;
    i_squash_ftqIdx  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic enq(input xaddr_t start);
    i_pred_vld       = 1'b1;
    i_pred_startAddr = start;
    i_pred_nextAddr  = start + 64'h10;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    enq(64'h7000);
    i_fetch_rdy = 1'b1;
    i_read_ftqIdx[0] = 4'd3;
    tick();
    tick();
    n_vec++; if (o_pred_rdy !== 1'b0) begin n_err++; $display("FAIL rst_pred_rdy got %b want 0", o_pred_rdy); end
    n_vec++; if (o_fetch_vld !== 1'b0) begin n_err++; $display("FAIL rst_fetch_vld got %b want 0", o_fetch_vld); end
    n_vec++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", o_count); end
    n_vec++; if (o_fetch_startAddr !== 64'h0) begin n_err++; $display("FAIL rst_fetch_start got %0h want 0", o_fetch_startAddr); end
    n_vec++; if (o_read_ftqStartAddr[0] !== 64'h0) begin n_err++; $display("FAIL rst_read_start got %0h want 0", o_read_ftqStartAddr[0]); end
    idle();
    rst = 1'b1;
    #1;
    n_vec++; if (o_pred_rdy !== 1'b1) begin n_err++; $display("FAIL rst_exit_pred_rdy got %b want 1", o_pred_rdy); end
    tick();
    n_vec++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rst_exit_count got %0d want 0", o_count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      enq(64'h1000 + 64'(i * 16));
      #1;
      n_vec++; if (o_pred_rdy !== 1'b1) begin n_err++; $display("FAIL fill_rdy_%0d got %b want 1", i, o_pred_rdy); end
      tick();
    end
    enq(64'hDEAD0);
    #1;
    n_vec++; if (o_pred_rdy !== 1'b0) begin n_err++; $display("FAIL full_rdy got %b want 0", o_pred_rdy); end
    n_vec++; if (o_count !== 5'd16) begin n_err++; $display("FAIL full_count got %0d want 16", o_count); end
    tick();
    i_pred_vld = 1'b0;
    i_read_ftqIdx[0] = 4'd0;
    i_read_ftqIdx[1] = 4'd15;
    #1;
    n_vec++; if (o_count !== 5'd16) begin n_err++; $display("FAIL held_count got %0d want 16", o_count); end
    n_vec++; if (o_read_ftqStartAddr[0] !== 64'h1000) begin n_err++; $display("FAIL held_entry0 got %0h want 1000", o_read_ftqStartAddr[0]); end
    n_vec++; if (o_read_ftqStartAddr[1] !== 64'h10F0) begin n_err++; $display("FAIL held_entry15 got %0h want 10f0", o_read_ftqStartAddr[1]); end
    n_vec++; if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'd0) begin n_err++; $display("FAIL full_fetch got vld=%b idx=%0d want vld=1 idx=0", o_fetch_vld, o_fetch_ftqIdx); end
    // reset in the middle of an in-flight fetch handshake
    i_fetch_rdy = 1'b1;
    rst = 1'b0;
    tick();
    n_vec++; if (o_count !== 5'd0 || o_pred_rdy !== 1'b0 || o_fetch_vld !== 1'b0) begin n_err++; $display("FAIL midrst_state got cnt=%0d rdy=%b vld=%b want 0/0/0", o_count, o_pred_rdy, o_fetch_vld); end
    rst = 1'b1;
    i_fetch_rdy = 1'b0;
    #1;
    n_vec++; if (o_read_ftqStartAddr[0] !== 64'h0 || o_read_ftqStartAddr[1] !== 64'h0) begin n_err++; $display("FAIL midrst_cleared got %0h/%0h want 0/0", o_read_ftqStartAddr[0], o_read_ftqStartAddr[1]); end
    n_vec++; if (o_pred_rdy !== 1'b1 || o_fetch_vld !== 1'b0) begin n_err++; $display("FAIL midrst_exit got rdy=%b vld=%b want 1/0", o_pred_rdy, o_fetch_vld); end
  endtask

  task automatic test_fetch_latency();
    do_reset();
    enq(64'h8000);
    i_fetch_rdy = 1'b1;
    #1;
`ifdef FTQ_FETCH_BYPASS_EN
    n_vec++; if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'd0 || o_fetch_startAddr !== 64'h8000) begin n_err++; $display("FAIL lat_c0 got vld=%b idx=%0d start=%0h want 1/0/8000", o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr); end
`else
    n_vec++; if (o_fetch_vld !== 1'b0) begin n_err++; $display("FAIL lat_c0 got vld=%b want 0", o_fetch_vld); end
`endif
    tick();
    i_pred_vld = 1'b0;
    #1;
`ifdef FTQ_FETCH_BYPASS_EN
    n_vec++; if (o_fetch_vld !== 1'b0) begin n_err++; $display("FAIL lat_c1 got vld=%b want 0", o_fetch_vld); end
`else
    n_vec++; if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'd0 || o_fetch_startAddr !== 64'h8000 || o_fetch_nextAddr !== 64'h8010) begin n_err++; $display("FAIL lat_c1 got vld=%b idx=%0d start=%0h next=%0h want 1/0/8000/8010", o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr, o_fetch_nextAddr); end
`endif
    tick();
    n_vec++; if (o_fetch_vld !== 1'b0 || o_count !== 5'd1) begin n_err++; $display("FAIL lat_c2 got vld=%b cnt=%0d want 0/1", o_fetch_vld, o_count); end
  endtask

  task automatic test_squash();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      enq(64'h2000 + 64'(i * 16));
      tick();
    end
    i_pred_vld = 1'b0;
    i_fetch_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'(i) || o_fetch_startAddr !== 64'h2000 + 64'(i * 16)) begin n_err++; $display("FAIL sq_fetch_%0d got vld=%b idx=%0d start=%0h", i, o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr); end
      tick();
    end
    n_vec++; if (o_fetch_vld !== 1'b0 || o_count !== 5'd5) begin n_err++; $display("FAIL sq_drained got vld=%b cnt=%0d want 0/5", o_fetch_vld, o_count); end
    i_squash_vld = 1'b1;
    i_squash_ftqIdx = 4'd2;
    enq(64'hDEAD0);
    tick();
    idle();
    i_read_ftqIdx[0] = 4'd3;
    #1;
    n_vec++; if (o_count !== 5'd3 || o_fetch_vld !== 1'b0 || o_pred_rdy !== 1'b1) begin n_err++; $display("FAIL sq_state got cnt=%0d vld=%b rdy=%b want 3/0/1", o_count, o_fetch_vld, o_pred_rdy); end
    n_vec++; if (o_read_ftqStartAddr[0] !== 64'h2030) begin n_err++; $display("FAIL sq_dropped_enq got %0h want 2030", o_read_ftqStartAddr[0]); end
    enq(64'hAAAA0);
    tick();
    i_pred_vld = 1'b0;
    #1;
    n_vec++; if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'd3 || o_fetch_startAddr !== 64'hAAAA0 || o_count !== 5'd4) begin n_err++; $display("FAIL sq_reenq got vld=%b idx=%0d start=%0h cnt=%0d want 1/3/aaaa0/4", o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr, o_count); end
  endtask

  task automatic test_branchwb();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      enq(64'h3000 + 64'(i * 16));
      tick();
    end
    i_pred_vld = 1'b0;
    i_branchwb_vld = 2'b11;
    i_branchwbInfo[0] = '{ftq_idx: 4'd4, mispred: 1'b1, npc: 64'h100};
    i_branchwbInfo[1] = '{ftq_idx: 4'd4, mispred: 1'b1, npc: 64'h200};
    i_read_ftqIdx[0] = 4'd4;
    i_read_ftqIdx[1] = 4'd3;
    #1;
    n_vec++; if (o_read_ftqNextAddr[0] !== 64'h3050) begin n_err++; $display("FAIL wb_preedge got %0h want 3050", o_read_ftqNextAddr[0]); end
    tick();
    i_branchwb_vld = 2'b10;
    i_branchwbInfo[1] = '{ftq_idx: 4'd3, mispred: 1'b0, npc: 64'h999};
    #1;
    n_vec++; if (o_read_ftqNextAddr[0] !== 64'h100) begin n_err++; $display("FAIL wb_port0_wins got %0h want 100", o_read_ftqNextAddr[0]); end
    tick();
    n_vec++; if (o_read_ftqNextAddr[1] !== 64'h3040) begin n_err++; $display("FAIL wb_no_mispred got %0h want 3040", o_read_ftqNextAddr[1]); end
    i_branchwb_vld = 2'b11;
    i_branchwbInfo[0] = '{ftq_idx: 4'd2, mispred: 1'b1, npc: 64'h400};
    i_branchwbInfo[1] = '{ftq_idx: 4'd3, mispred: 1'b1, npc: 64'h300};
    i_read_ftqIdx[0] = 4'd2;
    tick();
    i_branchwb_vld = '0;
    #1;
    n_vec++; if (o_read_ftqNextAddr[0] !== 64'h400 || o_read_ftqNextAddr[1] !== 64'h300) begin n_err++; $display("FAIL wb_dual got %0h/%0h want 400/300", o_read_ftqNextAddr[0], o_read_ftqNextAddr[1]); end
    n_vec++; if (o_read_ftqStartAddr[1] !== 64'h3030) begin n_err++; $display("FAIL wb_start_kept got %0h want 3030", o_read_ftqStartAddr[1]); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int fk;
      int exp_cnt;
      enq(64'h5000 + 64'(k * 16));
      i_fetch_rdy = 1'b1;
      i_commit_vld = (k >= 2);
      i_commit_ftqIdx = 4'((k - 2) & 15);
      exp_cnt = (k < 2) ? k : 2;
`ifdef FTQ_FETCH_BYPASS_EN
      fk = k;
`else
      fk = k - 1;
`endif
      #1;
      n_vec++; if (o_count !== 5'(exp_cnt) || o_pred_rdy !== 1'b1) begin n_err++; $display("FAIL wrap_cnt_%0d got cnt=%0d rdy=%b want %0d/1", k, o_count, o_pred_rdy, exp_cnt); end
      if (fk >= 0) begin
        n_vec++; if (o_fetch_vld !== 1'b1 || o_fetch_ftqIdx !== 4'(fk & 15) || o_fetch_startAddr !== 64'h5000 + 64'(fk * 16)) begin n_err++; $display("FAIL wrap_fetch_%0d got vld=%b idx=%0d start=%0h want 1/%0d/%0h", k, o_fetch_vld, o_fetch_ftqIdx, o_fetch_startAddr, fk & 15, 64'h5000 + 64'(fk * 16)); end
      end
      tick();
    end
    idle();
    #1;
    n_vec++; if (o_count !== 5'd2) begin n_err++; $display("FAIL wrap_end_cnt got %0d want 2", o_count); end
    for (int j = 0; j < 14; j++) begin
      enq(64'h6000 + 64'(j * 16));
      tick();
    end
    i_pred_vld = 1'b0;
    #1;
    n_vec++; if (o_count !== 5'd16 || o_pred_rdy !== 1'b0) begin n_err++; $display("FAIL wrap_full got cnt=%0d rdy=%b want 16/0", o_count, o_pred_rdy); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_fill();
    test_fetch_latency();
    test_squash();
    test_branchwb();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
